// File: rtl/ib_lut_bank_ram.sv
// Bank-interleaved IB-LUT memory with independent read ports and a streaming
// line-load sequencer. One line holds one entry per bank, all at the same
// page index. The page index is what the loader walks through.

// Per-port read lane: splits the address into bank/page for the chosen
// interleave map and selects the entry. Purely combinational; the top level
// decides whether the result is registered.
module ib_lut_rd_mux #(
  parameter  int BANK_NUM        = 2,
  parameter  int PAGE_NUM        = 32,
  parameter  int PAGE_SIZE       = 4,
  parameter  int INTERLEAVE_TYPE = 0,
  localparam int BANK_AW         = $clog2(BANK_NUM),
  localparam int PAGE_AW         = $clog2(PAGE_NUM),
  localparam int ADDR_WIDTH      = BANK_AW + PAGE_AW
) (
  input  logic [PAGE_NUM-1:0][BANK_NUM-1:0][PAGE_SIZE-1:0] mem,
  input  logic [ADDR_WIDTH-1:0]                            addr,
  output logic [PAGE_SIZE-1:0]                             word
);
  logic [BANK_AW-1:0] bank;
  logic [PAGE_AW-1:0] page;

  generate
    if (INTERLEAVE_TYPE == 0) begin : g_bank_hi
      assign bank = addr[ADDR_WIDTH-1 -: BANK_AW];
      assign page = addr[PAGE_AW-1:0];
    end else begin : g_bank_lo
      assign bank = addr[BANK_AW-1:0];
      assign page = addr[ADDR_WIDTH-1 -: PAGE_AW];
    end
  endgenerate

  assign word = mem[page][bank];
endmodule

module ib_lut_bank_ram #(
  parameter  int BANK_NUM        = 2,
  parameter  int PAGE_NUM        = 32,
  parameter  int PAGE_SIZE       = 4,
  parameter  int INTERLEAVE_TYPE = 0,
  parameter  int ASYNC_RD_EN     = 1,
  parameter  int NUM_RD          = 2,
  localparam int BANK_AW         = $clog2(BANK_NUM),
  localparam int PAGE_AW         = $clog2(PAGE_NUM),
  localparam int ADDR_WIDTH      = BANK_AW + PAGE_AW,
  localparam int WDATA_SIZE      = PAGE_SIZE * BANK_NUM
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic                           ld_start,
  input  logic [PAGE_AW-1:0]             ld_base,
  input  logic [PAGE_AW:0]               ld_len,
  input  logic                           ld_valid,
  input  logic [WDATA_SIZE-1:0]          ld_data,
  output logic                           ld_ready,
  output logic                           ld_busy,
  output logic                           ld_done,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*PAGE_SIZE-1:0]    rd_data,
  output logic [NUM_RD-1:0]              rd_valid
);
  localparam int REM_W = PAGE_AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_t;

  ld_state_t          state;
  logic [PAGE_AW-1:0] wr_page;
  logic [REM_W-1:0]   remaining;
  logic               wr_en;

  // Storage is line-organised: one page index addresses an entry in every bank.
  logic [PAGE_NUM-1:0][BANK_NUM-1:0][PAGE_SIZE-1:0] mem;

  // A cycle with rst high never writes, so an aborted load stops cleanly.
  assign wr_en = ld_valid & ld_ready & ~rst;

  // Load sequencer: IDLE -> LOAD (one line per handshake) -> DONE pulse -> IDLE.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_page   <= '0;
      remaining <= '0;
      ld_ready  <= 1'b0;
      ld_busy   <= 1'b0;
      ld_done   <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        IDLE: if (ld_start) begin
          wr_page   <= ld_base;
          remaining <= (ld_len == '0) ? REM_W'(PAGE_NUM) : ld_len;
          ld_ready  <= 1'b1;
          ld_busy   <= 1'b1;
          state     <= LOAD;
        end
        LOAD: if (ld_valid) begin
          wr_page   <= wr_page + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == REM_W'(1)) begin
            ld_ready <= 1'b0;
            ld_busy  <= 1'b0;
            ld_done  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Line write; contents are intentionally not touched by reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_page] <= ld_data;
  end

  // Read lanes: the write lands on the clock edge, so a same-cycle read sees
  // the old line in both the combinational and registered flavours.
  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [PAGE_SIZE-1:0] word;

      ib_lut_rd_mux #(
        .BANK_NUM        (BANK_NUM),
        .PAGE_NUM        (PAGE_NUM),
        .PAGE_SIZE       (PAGE_SIZE),
        .INTERLEAVE_TYPE (INTERLEAVE_TYPE)
      ) u_mux (
        .mem  (mem),
        .addr (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
        .word (word)
      );

      if (ASYNC_RD_EN != 0) begin : g_async
        assign rd_data[p*PAGE_SIZE +: PAGE_SIZE] = word;
        assign rd_valid[p]                       = rd_en[p];
      end else begin : g_sync
        logic [PAGE_SIZE-1:0] data_q;
        logic                 vld_q;

        // Registered read; data holds while the port is idle.
        always_ff @(posedge sys_clk) begin
          if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
          end else begin
            vld_q <= rd_en[p];
            if (rd_en[p]) data_q <= word;
          end
        end

        assign rd_data[p*PAGE_SIZE +: PAGE_SIZE] = data_q;
        assign rd_valid[p]                       = vld_q;
      end
    end
  endgenerate
endmodule

// File: tb/tb_ib_lut_bank_ram.sv
// Bench for ib_lut_bank_ram: two instances (2-bank/32-page/{bank,page}/async
// and 4-bank/64-page/{page,bank}/sync) checked against line-array models.
module tb_ib_lut_bank_ram;
  logic sys_clk = 1'b0;
  logic rst;

  // dut0: BANK_NUM=2, PAGE_NUM=32, type 0, async
  logic        ld_start0, ld_valid0, ld_ready0, ld_busy0, ld_done0;
  logic [4:0]  ld_base0;
  logic [5:0]  ld_len0;
  logic [7:0]  ld_data0;
  logic [1:0]  rd_en0, rd_valid0;
  logic [11:0] rd_addr0;
  logic [7:0]  rd_data0;

  // dut1: BANK_NUM=4, PAGE_NUM=64, type 1, sync
  logic        ld_start1, ld_valid1, ld_ready1, ld_busy1, ld_done1;
  logic [5:0]  ld_base1;
  logic [6:0]  ld_len1;
  logic [15:0] ld_data1;
  logic [1:0]  rd_en1, rd_valid1;
  logic [15:0] rd_addr1;
  logic [7:0]  rd_data1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  m0 [32];
  logic [15:0] m1 [64];
  logic [3:0]  prev1 [2];

  always #5 sys_clk = ~sys_clk;

  ib_lut_bank_ram #(.BANK_NUM(2), .PAGE_NUM(32), .PAGE_SIZE(4), .INTERLEAVE_TYPE(0),
                    .ASYNC_RD_EN(1), .NUM_RD(2)) dut0 (
    .sys_clk(sys_clk), .rst(rst), .ld_start(ld_start0), .ld_base(ld_base0),
    .ld_len(ld_len0), .ld_valid(ld_valid0), .ld_data(ld_data0), .ld_ready(ld_ready0),
    .ld_busy(ld_busy0), .ld_done(ld_done0), .rd_en(rd_en0), .rd_addr(rd_addr0),
    .rd_data(rd_data0), .rd_valid(rd_valid0));

  ib_lut_bank_ram #(.BANK_NUM(4), .PAGE_NUM(64), .PAGE_SIZE(4), .INTERLEAVE_TYPE(1),
                    .ASYNC_RD_EN(0), .NUM_RD(2)) dut1 (
    .sys_clk(sys_clk), .rst(rst), .ld_start(ld_start1), .ld_base(ld_base1),
    .ld_len(ld_len1), .ld_valid(ld_valid1), .ld_data(ld_data1), .ld_ready(ld_ready1),
    .ld_busy(ld_busy1), .ld_done(ld_done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .rd_valid(rd_valid1));

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Type 0: address = bank*PAGE_NUM + page
  function automatic logic [3:0] exp0(input int a);
    int bank, page;
    bank = a / 32;
    page = a % 32;
    return 4'((m0[page] >> (4 * bank)) & 8'hF);
  endfunction

  // Type 1: address = page*BANK_NUM + bank
  function automatic logic [3:0] exp1(input int a);
    int bank, page;
    bank = a % 4;
    page = a / 4;
    return 4'((m1[page] >> (4 * bank)) & 16'hF);
  endfunction

  // vmode: 0 always valid, 1 random, 2 pattern; dmode: 0 {k,~k}, 1 random, 2 constant
  task automatic load0(input int base, input int len, input int vmode, input int dmode,
                       input logic [7:0] dconst, input logic [31:0] vpat);
    int n, page, acc, cyc;
    logic v;
    logic [7:0] d;
    n = (len == 0) ? 32 : len;
    page = base; acc = 0; cyc = 0;
    ld_start0 = 1'b1; ld_base0 = 5'(base); ld_len0 = 6'(len);
    tick();
    ld_start0 = 1'b0;
    chk("ld0_ready_rise", ld_ready0, 1);
    chk("ld0_busy", ld_busy0, 1);
    while (acc < n && cyc < 200) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'($urandom_range(0, 1)) : vpat[cyc % 32];
      d = (dmode == 0) ? 8'((page % 16) * 16 + (15 - page % 16)) :
          (dmode == 1) ? 8'($urandom) : dconst;
      ld_valid0 = v; ld_data0 = d;
      if (cyc == 1) begin ld_start0 = 1'b1; ld_base0 = 5'(base + 9); end
      chk("ld0_ready", ld_ready0, 1);
      tick();
      ld_start0 = 1'b0;
      if (v) begin m0[page] = d; page = (page + 1) % 32; acc++; end
      cyc++;
      if (acc < n) chk("ld0_early_done", ld_done0, 0);
    end
    ld_valid0 = 1'b0;
    chk("ld0_count", acc, n);
    chk("ld0_done", ld_done0, 1);
    chk("ld0_busy_clr", ld_busy0, 0);
    tick();
    chk("ld0_done_once", ld_done0, 0);
  endtask

  task automatic load1(input int base, input int len, input int vmode, input int dmode,
                       input logic [15:0] dconst);
    int n, page, acc, cyc;
    logic v;
    logic [15:0] d;
    n = (len == 0) ? 64 : len;
    page = base; acc = 0; cyc = 0;
    ld_start1 = 1'b1; ld_base1 = 6'(base); ld_len1 = 7'(len);
    tick();
    ld_start1 = 1'b0;
    chk("ld1_ready_rise", ld_ready1, 1);
    while (acc < n && cyc < 400) begin
      v = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      d = (dmode == 2) ? dconst : 16'($urandom);
      ld_valid1 = v; ld_data1 = d;
      if (cyc == 1) begin ld_start1 = 1'b1; ld_base1 = 6'(base + 9); end
      tick();
      ld_start1 = 1'b0;
      if (v) begin m1[page] = d; page = (page + 1) % 64; acc++; end
      cyc++;
    end
    ld_valid1 = 1'b0;
    chk("ld1_count", acc, n);
    chk("ld1_done", ld_done1, 1);
    tick();
    chk("ld1_done_once", ld_done1, 0);
  endtask

  task automatic rd0_check(input int a0, input int a1);
    rd_en0 = 2'b11; rd_addr0 = {6'(a1), 6'(a0)};
    #1;
    chk("rd0_p0", rd_data0[3:0], exp0(a0));
    chk("rd0_p1", rd_data0[7:4], exp0(a1));
    chk("rd0_vld", rd_valid0, 2'b11);
    rd_en0 = 2'b00;
  endtask

  task automatic rd1_step(input int a0, input int a1, input logic [1:0] en);
    rd_en1 = en; rd_addr1 = {8'(a1), 8'(a0)};
    tick();
    if (en[0]) prev1[0] = exp1(a0);
    if (en[1]) prev1[1] = exp1(a1);
    chk("rd1_p0", rd_data1[3:0], prev1[0]);
    chk("rd1_p1", rd_data1[7:4], prev1[1]);
    chk("rd1_vld", rd_valid1, en);
    rd_en1 = 2'b00;
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1;
    ld_start0 = 0; ld_valid0 = 0; ld_base0 = 0; ld_len0 = 0; ld_data0 = 0; rd_en0 = 0; rd_addr0 = 0;
    ld_start1 = 0; ld_valid1 = 0; ld_base1 = 0; ld_len1 = 0; ld_data1 = 0; rd_en1 = 0; rd_addr1 = 0;
    prev1[0] = 4'h0; prev1[1] = 4'h0;
    tick(); tick();
    chk("rst_ready0", ld_ready0, 0);
    chk("rst_busy0", ld_busy0, 0);
    chk("rst_done0", ld_done0, 0);
    chk("rst_vld0", rd_valid0, 0);
    chk("rst_ready1", ld_ready1, 0);
    chk("rst_busy1", ld_busy1, 0);
    chk("rst_vld1", rd_valid1, 0);
    chk("rst_data1", rd_data1, 0);
    rst = 1'b0;
    tick();

    // Full load, len 0 = 32 lines of {k,~k}
    load0(0, 0, 0, 0, 8'h00, 32'h0);
    rd_en0 = 2'b11; rd_addr0 = {6'd5, 6'd37};
    #1;
    chk("tp_bank1_pg5", rd_data0[3:0], 4'h5);
    chk("tp_bank0_pg5", rd_data0[7:4], 4'hA);
    rd_en0 = 2'b00;
    for (int i = 0; i < 16; i++) rd0_check($urandom_range(0, 63), $urandom_range(0, 63));

    // Page wrap: 31, 0, 1 written; 2 untouched
    load0(31, 3, 1, 1, 8'h00, 32'h0);
    rd0_check(31, 63); rd0_check(0, 32); rd0_check(1, 33); rd0_check(2, 34);

    // Backpressure 1,0,0,1,1 with len 3, plus an ignored restart to base+9
    load0(10, 3, 2, 1, 8'h00, 32'b11001);
    rd0_check(10, 42); rd0_check(11, 43); rd0_check(12, 44); rd0_check(13, 19);

    // Collision on page 7, async
    load0(7, 1, 0, 2, 8'h11, 32'h0);
    ld_start0 = 1'b1; ld_base0 = 5'd7; ld_len0 = 6'd1;
    tick();
    ld_start0 = 1'b0; ld_valid0 = 1'b1; ld_data0 = 8'h99;
    rd_en0 = 2'b11; rd_addr0 = {6'd39, 6'd7};
    #1;
    chk("col0_old", rd_data0, 8'h11);
    tick();
    ld_valid0 = 1'b0;
    m0[7] = 8'h99;
    chk("col0_new", rd_data0, 8'h99);
    chk("col0_done", ld_done0, 1);
    rd_en0 = 2'b00;
    tick();

    // Reset after 2 of 5 lines
    ld_start0 = 1'b1; ld_base0 = 5'd20; ld_len0 = 6'd5;
    tick();
    ld_start0 = 1'b0; ld_valid0 = 1'b1;
    d = 8'($urandom); ld_data0 = d;
    tick();
    m0[20] = d;
    d = 8'($urandom); ld_data0 = d;
    tick();
    m0[21] = d;
    ld_valid0 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    prev1[0] = 4'h0; prev1[1] = 4'h0;
    chk("abort_busy", ld_busy0, 0);
    chk("abort_ready", ld_ready0, 0);
    chk("abort_done", ld_done0, 0);
    tick();
    chk("abort_no_done", ld_done0, 0);
    rd0_check(20, 52); rd0_check(21, 53); rd0_check(22, 54);

    // dut1: page 3 = {D,C,B,A}, read bank 2 and bank 0
    load1(3, 1, 0, 2, 16'hDCBA);
    chk("sync_vld_idle", rd_valid1, 0);
    rd1_step(14, 12, 2'b11);
    chk("tp_sync_c", rd_data1[3:0], 4'hC);
    rd1_step(0, 0, 2'b00);
    rd1_step(15, 13, 2'b10);

    // Full random load with random backpressure, then random reads
    load1(0, 0, 1, 1, 16'h0);
    for (int i = 0; i < 20; i++)
      rd1_step($urandom_range(0, 255), $urandom_range(0, 255), 2'($urandom_range(0, 3)));

    // Collision on page 7, sync
    load1(7, 1, 0, 2, 16'h1111);
    ld_start1 = 1'b1; ld_base1 = 6'd7; ld_len1 = 7'd1;
    tick();
    ld_start1 = 1'b0; ld_valid1 = 1'b1; ld_data1 = 16'h9999;
    rd_en1 = 2'b11; rd_addr1 = {8'd31, 8'd28};
    tick();
    ld_valid1 = 1'b0;
    chk("col1_old", rd_data1, 8'h11);
    chk("col1_done", ld_done1, 1);
    m1[7] = 16'h9999;
    tick();
    chk("col1_new", rd_data1, 8'h99);
    prev1[0] = 4'h9; prev1[1] = 4'h9;
    rd_en1 = 2'b00;
    rd1_step(30, 29, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
